video_frame_arbiter: RTL and testbench
======================================

// Module: video_frame_arbiter
// PURPOSE
//  Shares the single greyscale filter datapath between two AXI4-Stream video sources at frame granularity.
//  Sits between two video input bridges and the filter's s_axis_video port.
//  Grants one source per frame with round-robin arbitration and holds the grant until that frame's final line ends.
//  Tags the forwarded stream with its source ID and counts completed frames and discarded pixels.
// PARAMETERS
//  DATA_W   24   pixel width, packed RGB 8:8:8
//  LINES    720  lines per frame; tlast beats that complete one frame
//  CNT_W    16   width of frame_cnt0/1 and drop_cnt
// PORTS
//  aclk                  in   1       clock
//  areset                in   1       asynchronous, active-high reset
//  enable                in   1       1 = new frames may be granted; 0 = finish the current frame, then idle
//  s0_axis_video_tdata   in   DATA_W  source 0 pixel
//  s0_axis_video_tvalid  in   1       source 0 valid
//  s0_axis_video_tuser   in   1       source 0 start of frame (SOF)
//  s0_axis_video_tlast   in   1       source 0 end of line (EOL)
//  s0_axis_video_tready  out  1       source 0 ready
//  s1_axis_video_*       --   --      same set as s0, for source 1
//  m_axis_video_tdata    out  DATA_W  pixel to filter
//  m_axis_video_tvalid   out  1       valid to filter
//  m_axis_video_tuser    out  1       SOF to filter
//  m_axis_video_tlast    out  1       EOL to filter
//  m_axis_video_tid      out  1       source ID of the current frame
//  m_axis_video_tready   in   1       ready from filter
//  grant                 out  2       one-hot grant; 00 = idle
//  frame_cnt0            out  CNT_W   completed frames, source 0, wraps
//  frame_cnt1            out  CNT_W   completed frames, source 1, wraps
//  drop_cnt              out  CNT_W   beats discarded while hunting for SOF, wraps
//  err_early_sof         out  1       one-cycle pulse: SOF accepted mid-frame on the granted source
// BEHAVIOUR
//  Reset (async assert, release on aclk)
//   - grant=00; state=IDLE; all counters 0; err_early_sof=0.
//   - last_grant=1, so source 0 wins the first tie.
//   - m_axis_video_tvalid=0, s0/s1 tready=0, tid=0.
//   - Reset asserted mid-frame aborts the frame immediately; no counter is updated.
//  FSM states: IDLE, PASS0, PASS1 (grant, tid and the counters are registered).
//  IDLE
//   - Source n requests when sn_tvalid && sn_tuser && enable.
//   - One request -> PASSn next cycle.
//   - Two requests -> grant the source != last_grant.
//   - Source with tvalid && !tuser: tready=1, beat discarded, drop_cnt += 1 (each source counted separately, both may drop in one cycle: +2).
//   - Source with tvalid && tuser: tready=0 (held) until granted.
//   - m_axis_video_tvalid=0.
//  PASSn
//   - Zero-latency combinational mux:
//     m_tdata/tuser/tlast/tvalid = sn_*; sn_tready = m_axis_video_tready.
//   - Other source: tready=0, no drop counting.
//   - tid=n.
//   - Beat accepted = sn_tvalid && m_axis_video_tready.
//   - line_cnt (clog2(LINES) bits) += 1 on each accepted beat with tlast.
//   - Accepted tlast with line_cnt==LINES-1: frame_cntn += 1, last_grant=n, line_cnt=0.
//     Next state: IDLE; or, if the other source requests, go directly to PASS(other) with no extra bubble.
//   - Accepted tuser on a beat other than the frame's first: err_early_sof=1 for 1 cycle, line_cnt=0,
//     beat forwarded, grant kept (treated as a new frame; no frame_cnt increment).
//  Arbitration latency: exactly 1 idle cycle between SOF presented in IDLE and its transfer.
//  enable deasserted in PASSn: the frame completes normally, then IDLE; no grants while enable=0.
//  Backpressure: m_axis_video_tready low stalls only the granted source; the datapath holds no state.
//  Counters wrap 2^CNT_W-1 -> 0 silently.
// TESTING
//  T1 reset
//   - areset pulse mid-frame -> grant=00, all tready=0, counters 0 within the same cycle.
//  T2 single source
//   - Source 0 sends 1 frame, LINES=4, 8 px/line, tready=1.
//   - Expect: 1-cycle bubble, then 32 beats forwarded, tid=0, frame_cnt0=1, grant returns to 00.
//  T3 round-robin
//   - Both sources present SOF in IDLE repeatedly.
//   - Expect grant order 0,1,0,1 and frame_cnt0=frame_cnt1=2 after 4 frames.
//   - Back-to-back frames have no idle cycle.
//  T4 SOF hunt
//   - Source 1 starts mid-frame: 5 beats without tuser, then SOF.
//   - Expect drop_cnt=5, then source 1 granted on its SOF.
//  T5 early SOF and backpressure
//   - Granted source raises tuser on line 2; m_axis_video_tready toggles 1/0.
//   - Expect err_early_sof one pulse, line_cnt=0, frame completes after LINES more lines.
//   - Expect no beat lost or duplicated.
//  T6 enable
//   - Drop enable mid-frame.
//   - Expect current frame completes, then IDLE with no further grants despite pending SOF on both sources.

Source files
------------

// File: rtl/video_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_arbiter
// Brief    : Frame-granular round-robin arbiter sharing one AXI4-Stream video
//            datapath between two sources, with frame/drop/early-SOF status.
// Revision : 1.0
// ============================================================================
module video_frame_arbiter #(
    parameter int DATA_W = 24,
    parameter int LINES  = 720,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,

    input  logic [DATA_W-1:0] s0_axis_video_tdata,
    input  logic              s0_axis_video_tvalid,
    input  logic              s0_axis_video_tuser,
    input  logic              s0_axis_video_tlast,
    output logic              s0_axis_video_tready,

    input  logic [DATA_W-1:0] s1_axis_video_tdata,
    input  logic              s1_axis_video_tvalid,
    input  logic              s1_axis_video_tuser,
    input  logic              s1_axis_video_tlast,
    output logic              s1_axis_video_tready,

    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    output logic              m_axis_video_tid,
    input  logic              m_axis_video_tready,

    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  frame_cnt0,
    output logic [CNT_W-1:0]  frame_cnt1,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              err_early_sof
);

    localparam int                  c_line_w    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [c_line_w-1:0] c_last_line = c_line_w'(LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS0 = 2'd1,
        ST_PASS1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_first_beat;
    logic [c_line_w-1:0] r_line_cnt;
    logic [c_line_w-1:0] w_line_base;
    logic [CNT_W-1:0]    r_frame_cnt0;
    logic [CNT_W-1:0]    r_frame_cnt1;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                r_err_early_sof;
    logic                r_tid;
    logic [1:0]          r_grant;

    logic w_req0;
    logic w_req1;
    logic w_drop0;
    logic w_drop1;
    logic w_passing;
    logic w_sel;
    logic w_sel_valid;
    logic w_sel_user;
    logic w_sel_last;
    logic w_accept;
    logic w_early_sof;
    logic w_frame_done;

    assign w_req0 = s0_axis_video_tvalid && s0_axis_video_tuser && enable;
    assign w_req1 = s1_axis_video_tvalid && s1_axis_video_tuser && enable;

    // Beats ahead of an SOF are swallowed while idle so a source joining mid-frame resyncs.
    assign w_drop0 = (r_state == ST_IDLE) && s0_axis_video_tvalid && !s0_axis_video_tuser && !areset;
    assign w_drop1 = (r_state == ST_IDLE) && s1_axis_video_tvalid && !s1_axis_video_tuser && !areset;

    assign w_passing   = (r_state == ST_PASS0) || (r_state == ST_PASS1);
    assign w_sel       = (r_state == ST_PASS1);
    assign w_sel_valid = w_sel ? s1_axis_video_tvalid : s0_axis_video_tvalid;
    assign w_sel_user  = w_sel ? s1_axis_video_tuser  : s0_axis_video_tuser;
    assign w_sel_last  = w_sel ? s1_axis_video_tlast  : s0_axis_video_tlast;

    assign w_accept     = w_passing && w_sel_valid && m_axis_video_tready;
    assign w_early_sof  = w_accept && w_sel_user && !r_first_beat;
    // An early SOF restarts the frame, so this beat counts as line 0.
    assign w_line_base  = w_early_sof ? '0 : r_line_cnt;
    assign w_frame_done = w_accept && w_sel_last && (w_line_base == c_last_line);

    always_comb begin
        w_next_state         = r_state;
        m_axis_video_tdata   = '0;
        m_axis_video_tvalid  = 1'b0;
        m_axis_video_tuser   = 1'b0;
        m_axis_video_tlast   = 1'b0;
        s0_axis_video_tready = 1'b0;
        s1_axis_video_tready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s0_axis_video_tready = w_drop0;
                s1_axis_video_tready = w_drop1;
                if (w_req0 && w_req1) begin
                    w_next_state = r_last_grant ? ST_PASS0 : ST_PASS1;
                end else if (w_req0) begin
                    w_next_state = ST_PASS0;
                end else if (w_req1) begin
                    w_next_state = ST_PASS1;
                end
            end
            ST_PASS0: begin
                m_axis_video_tdata   = s0_axis_video_tdata;
                m_axis_video_tvalid  = s0_axis_video_tvalid;
                m_axis_video_tuser   = s0_axis_video_tuser;
                m_axis_video_tlast   = s0_axis_video_tlast;
                s0_axis_video_tready = m_axis_video_tready;
                if (w_frame_done) begin
                    w_next_state = w_req1 ? ST_PASS1 : ST_IDLE;
                end
            end
            ST_PASS1: begin
                m_axis_video_tdata   = s1_axis_video_tdata;
                m_axis_video_tvalid  = s1_axis_video_tvalid;
                m_axis_video_tuser   = s1_axis_video_tuser;
                m_axis_video_tlast   = s1_axis_video_tlast;
                s1_axis_video_tready = m_axis_video_tready;
                if (w_frame_done) begin
                    w_next_state = w_req0 ? ST_PASS0 : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state         <= ST_IDLE;
            r_grant         <= 2'b00;
            r_tid           <= 1'b0;
            r_last_grant    <= 1'b1;
            r_first_beat    <= 1'b1;
            r_line_cnt      <= '0;
            r_frame_cnt0    <= '0;
            r_frame_cnt1    <= '0;
            r_drop_cnt      <= '0;
            r_err_early_sof <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_grant         <= {w_next_state == ST_PASS1, w_next_state == ST_PASS0};
            r_tid           <= (w_next_state == ST_PASS1);
            r_err_early_sof <= w_early_sof;
            r_drop_cnt      <= r_drop_cnt + CNT_W'(w_drop0) + CNT_W'(w_drop1);
            if (w_accept) begin
                r_first_beat <= 1'b0;
                if (w_frame_done) begin
                    r_line_cnt   <= '0;
                    r_last_grant <= w_sel;
                    if (w_sel) begin
                        r_frame_cnt1 <= r_frame_cnt1 + 1'b1;
                    end else begin
                        r_frame_cnt0 <= r_frame_cnt0 + 1'b1;
                    end
                end else if (w_sel_last) begin
                    r_line_cnt <= w_line_base + 1'b1;
                end else begin
                    r_line_cnt <= w_line_base;
                end
            end
            // Re-arm so the next accepted beat is recognised as the frame's legitimate SOF.
            if ((r_state == ST_IDLE) || w_frame_done) begin
                r_first_beat <= 1'b1;
            end
        end
    end

    assign grant            = r_grant;
    assign m_axis_video_tid = r_tid;
    assign frame_cnt0       = r_frame_cnt0;
    assign frame_cnt1       = r_frame_cnt1;
    assign drop_cnt         = r_drop_cnt;
    assign err_early_sof    = r_err_early_sof;

endmodule
`default_nettype wire

// File: tb/tb_video_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_arbiter
// Brief    : Scoreboard bench for video_frame_arbiter (per-source beat queues).
// Revision : 1.0
// ============================================================================
module tb_video_frame_arbiter;

    localparam int DATA_W = 24;
    localparam int LINES  = 4;
    localparam int CNT_W  = 16;

    logic              aclk   = 1'b0;
    logic              areset = 1'b1;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] s0_tdata = '0;
    logic              s0_tvalid = 1'b0, s0_tuser = 1'b0, s0_tlast = 1'b0;
    logic              s0_tready;
    logic [DATA_W-1:0] s1_tdata = '0;
    logic              s1_tvalid = 1'b0, s1_tuser = 1'b0, s1_tlast = 1'b0;
    logic              s1_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid, m_tuser, m_tlast, m_tid;
    logic              m_tready = 1'b1;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  frame_cnt0, frame_cnt1, drop_cnt;
    logic              err_early_sof;

    video_frame_arbiter #(.DATA_W(DATA_W), .LINES(LINES), .CNT_W(CNT_W)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .enable               (enable),
        .s0_axis_video_tdata  (s0_tdata),
        .s0_axis_video_tvalid (s0_tvalid),
        .s0_axis_video_tuser  (s0_tuser),
        .s0_axis_video_tlast  (s0_tlast),
        .s0_axis_video_tready (s0_tready),
        .s1_axis_video_tdata  (s1_tdata),
        .s1_axis_video_tvalid (s1_tvalid),
        .s1_axis_video_tuser  (s1_tuser),
        .s1_axis_video_tlast  (s1_tlast),
        .s1_axis_video_tready (s1_tready),
        .m_axis_video_tdata   (m_tdata),
        .m_axis_video_tvalid  (m_tvalid),
        .m_axis_video_tuser   (m_tuser),
        .m_axis_video_tlast   (m_tlast),
        .m_axis_video_tid     (m_tid),
        .m_axis_video_tready  (m_tready),
        .grant                (grant),
        .frame_cnt0           (frame_cnt0),
        .frame_cnt1           (frame_cnt1),
        .drop_cnt             (drop_cnt),
        .err_early_sof        (err_early_sof)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              u;
        logic              l;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    sof_log[$];
    beat_t mon_beat, mon_exp;

    int checks = 0, errors = 0;
    int cyc = 0, fwd_cnt = 0, got_err = 0;
    int exp_frames[2] = '{0, 0};
    int exp_drop = 0, exp_err = 0;
    int pres_cyc[2] = '{0, 0};
    int sof_acc_cyc = 0, first_acc_cyc = -1, last_acc_cyc = 0;
    int m_mode = 0;
    bit abort = 1'b0;
    int f0, g;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Sink-ready pattern: 0 = always ready, 1 = toggle, else random.
    initial forever begin
        @(posedge aclk);
        #1;
        case (m_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the expected beat of the tagged source on every transfer.
    initial forever begin
        @(negedge aclk);
        if (!areset) begin
            if (err_early_sof) got_err++;
            if (m_tvalid) check("grant_vs_tid", grant, m_tid ? 2 : 1);
            if (grant == 2'b00) check("idle_no_valid", m_tvalid, 0);
            if (m_tvalid && m_tready) begin
                mon_beat = {m_tdata, m_tuser, m_tlast};
                if ((m_tid == 1'b0 && exp_q0.size() == 0) || (m_tid == 1'b1 && exp_q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected actual_tid=%0d data=%0h required=none", m_tid, m_tdata);
                end else begin
                    if (m_tid) mon_exp = exp_q1.pop_front();
                    else       mon_exp = exp_q0.pop_front();
                    check("beat", mon_beat, mon_exp);
                end
                fwd_cnt++;
                last_acc_cyc = cyc;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (m_tuser) begin
                    sof_log.push_back(int'(m_tid));
                    sof_acc_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_src(input int src, input bit v, input logic [DATA_W-1:0] d, input bit u, input bit l);
        if (src == 0) begin
            s0_tvalid = v; s0_tdata = d; s0_tuser = u; s0_tlast = l;
        end else begin
            s1_tvalid = v; s1_tdata = d; s1_tuser = u; s1_tlast = l;
        end
    endtask

    task automatic drive_beat(input int src, input logic [DATA_W-1:0] d, input bit u, input bit l);
        bit done = 1'b0;
        int n = 0;
        set_src(src, 1'b1, d, u, l);
        if (u) pres_cyc[src] = cyc;
        while (!done) begin
            @(negedge aclk);
            if (abort) break;
            done = (src == 0) ? s0_tready : s1_tready;
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 3000) begin
                check("drive_timeout", n, 0);
                abort = 1'b1;
                break;
            end
        end
        set_src(src, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_junk(input int src, input int n);
        for (int i = 0; i < n; i++) begin
            if (abort) return;
            exp_drop++;
            drive_beat(src, DATA_W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    // One complete frame; early_line > 0 restarts it with an SOF at that line.
    task automatic send_frame(input int src, input int ppl, input int early_line, input int gapmax);
        int    nlines = (early_line > 0) ? early_line + LINES : LINES;
        int    gap;
        beat_t b;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < ppl; p++) begin
                if (abort) return;
                b.d = DATA_W'($urandom);
                b.u = (p == 0) && (l == 0 || l == early_line);
                b.l = (p == ppl - 1);
                if (b.u && l != 0) exp_err++;
                if (src == 0) exp_q0.push_back(b);
                else          exp_q1.push_back(b);
                if (gapmax > 0) begin
                    gap = $urandom_range(0, gapmax);
                    repeat (gap) begin @(posedge aclk); #1; end
                end
                drive_beat(src, b.d, b.u, b.l);
            end
        end
        if (!abort) exp_frames[src]++;
    endtask

    task automatic wait_fwd(input int target);
        int n = 0;
        while (fwd_cnt < target && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (fwd_cnt < target) check("wait_fwd_timeout", fwd_cnt, target);
    endtask

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        exp_drop = 0;
        exp_err  = 0;
        got_err  = 0;
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tid", m_tid, 0);
        check("rst_cnt0", frame_cnt0, 0);
        check("rst_drop", drop_cnt, 0);
        areset = 1'b0;
        enable = 1'b1;
        @(posedge aclk);
        #1;

        // Single source, 4 lines x 8 pixels
        m_mode = 0;
        f0 = fwd_cnt;
        send_frame(0, 8, -1, 0);
        check("t2_grant_idle", grant, 0);
        check("t2_latency", sof_acc_cyc - pres_cyc[0], 1);
        check("t2_beats", fwd_cnt - f0, 32);
        check("t2_frame_cnt0", frame_cnt0, exp_frames[0]);

        // Asynchronous reset in the middle of a source-1 frame
        fork
            send_frame(1, 4, -1, 0);
            begin
                wait_fwd(fwd_cnt + 6);
                @(posedge aclk);
                #2;
                areset = 1'b1;
                #1;
                check("t1_grant", grant, 0);
                check("t1_s0_tready", s0_tready, 0);
                check("t1_s1_tready", s1_tready, 0);
                check("t1_m_tvalid", m_tvalid, 0);
                check("t1_cnt0", frame_cnt0, 0);
                check("t1_cnt1", frame_cnt1, 0);
                check("t1_drop", drop_cnt, 0);
                abort = 1'b1;
            end
        join
        clear_model();
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        abort  = 1'b0;
        @(posedge aclk);
        #1;

        // Round robin: both sources keep an SOF pending
        sof_log.delete();
        first_acc_cyc = -1;
        f0 = fwd_cnt;
        fork
            begin
                send_frame(0, $urandom_range(1, 3), -1, 0);
                send_frame(0, $urandom_range(1, 3), -1, 0);
            end
            begin
                send_frame(1, $urandom_range(1, 3), -1, 0);
                send_frame(1, $urandom_range(1, 3), -1, 0);
            end
        join
        check("t3_sof_count", sof_log.size(), 4);
        for (int i = 0; i < sof_log.size() && i < 4; i++) check("t3_order", sof_log[i], i % 2);
        check("t3_no_bubble", last_acc_cyc - first_acc_cyc + 1, fwd_cnt - f0);
        check("t3_cnt0", frame_cnt0, exp_frames[0]);
        check("t3_cnt1", frame_cnt1, exp_frames[1]);

        // SOF hunt on source 1
        send_junk(1, 5);
        check("t4_drop", drop_cnt, exp_drop);
        send_frame(1, 3, -1, 1);
        check("t4_cnt1", frame_cnt1, exp_frames[1]);

        // Early SOF on line 2 with toggling backpressure
        m_mode = 1;
        send_frame(0, 3, 2, 0);
        check("t5_cnt0", frame_cnt0, exp_frames[0]);
        m_mode = 0;
        repeat (3) begin @(posedge aclk); #1; end
        check("t5_err_pulses", got_err, exp_err);
        check("t5_drop", drop_cnt, exp_drop);
        check("t5_q0_empty", exp_q0.size(), 0);

        // Enable dropped mid-frame
        m_mode = 2;
        fork
            send_frame(0, 4, -1, 1);
            begin
                wait_fwd(fwd_cnt + 5);
                enable = 1'b0;
            end
        join
        check("t6_cnt0", frame_cnt0, exp_frames[0]);
        f0 = fwd_cnt;
        fork
            send_frame(0, 2, -1, 0);
            send_frame(1, 2, -1, 0);
            begin
                repeat (40) @(posedge aclk);
                check("t6_grant_idle", grant, 0);
                abort = 1'b1;
            end
        join
        check("t6_no_fwd", fwd_cnt - f0, 0);
        check("t6_drop", drop_cnt, exp_drop);
        exp_q0.delete();
        exp_q1.delete();
        abort  = 1'b0;
        enable = 1'b1;
        @(posedge aclk);
        #1;

        // Randomised mixed traffic
        for (int r = 0; r < 6; r++) begin
            fork
                for (int k = 0; k < 4; k++) begin
                    send_junk(0, $urandom_range(0, 2));
                    send_frame(0, $urandom_range(1, 4),
                               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LINES - 1)) : -1, 2);
                end
                for (int k = 0; k < 4; k++) begin
                    send_junk(1, $urandom_range(0, 2));
                    send_frame(1, $urandom_range(1, 4),
                               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LINES - 1)) : -1, 2);
                end
            join
            repeat ($urandom_range(0, 5)) begin @(posedge aclk); #1; end
        end
        repeat (10) begin @(posedge aclk); #1; end
        check("rnd_cnt0", frame_cnt0, exp_frames[0] % (1 << CNT_W));
        check("rnd_cnt1", frame_cnt1, exp_frames[1] % (1 << CNT_W));
        check("rnd_drop", drop_cnt, exp_drop % (1 << CNT_W));
        check("rnd_err", got_err, exp_err);
        check("rnd_q0_empty", exp_q0.size(), 0);
        check("rnd_q1_empty", exp_q1.size(), 0);
        check("rnd_grant_idle", grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
